// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the synchronous dual-port RAM.
// The default geometry is 16 words of 8 bits with 4-bit addresses.
package dpram_pkg;

  localparam int RAM_WIDTH_DEF = 8;
  localparam int RAM_DEPTH_DEF = 16;
  localparam int ADD_SIZE_DEF  = 4;

  // An address selects a real word only when it is below the configured depth.
  // Any address at or above the depth has no storage behind it.
  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/synchronous_dualport_ram.sv
// Simple dual-port synchronous RAM with one write port and one read port on a
// single clock. Storage is register-based, and read data is registered, so a
// read has one cycle of latency.
// When the two ports hit the same address in the same cycle, the read returns
// the old word (read-first). Defining RAM_BYPASS_EN changes this to
// write-first, so the read returns the incoming data_in instead.
module synchronous_dualport_ram
  import dpram_pkg::*;
#(
  parameter int ram_width = RAM_WIDTH_DEF,
  parameter int ram_depth = RAM_DEPTH_DEF,
  parameter int add_size  = ADD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ram_width-1:0] data_in,
  input  logic [add_size-1:0]  read_add,
  input  logic [add_size-1:0]  write_add,
  input  logic                 read,
  input  logic                 write,
  output logic [ram_width-1:0] data_out
);

  logic [ram_width-1:0] mem [ram_depth];
  logic                 wr_ok;
  logic                 rd_ok;
  logic [ram_width-1:0] rd_word;

  // Range qualification for both ports; out-of-range accesses have no storage.
  always_comb begin
    wr_ok = write && addr_in_range(32'(write_add), ram_depth);
    rd_ok = addr_in_range(32'(read_add), ram_depth);
  end

  // Storage array: cleared by reset, and written on an enabled in-range write.
  // NOTE: the whole array is reset on purpose, because after reset every word
  // must read as 0. This forces flops rather than a RAM macro, which is
  // acceptable at this size.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ram_depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      // NOTE: sequential state always uses non-blocking assignment, so reads
      // in this same edge still see the pre-write contents.
      mem[write_add] <= data_in;
    end
  end

  // Word selection for the read port: old contents by default, 0 when the
  // address is out of range, and data_in on a collision in the bypass build.
  always_comb begin
    // NOTE: default first, so no path through this block leaves rd_word
    // unassigned and infers a latch.
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[read_add];
    end
`ifdef RAM_BYPASS_EN
    if (wr_ok && (read_add == write_add)) begin
      rd_word = data_in;
    end
`endif
  end

  // Registered read data: loads on an enabled read and holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else if (read) begin
      data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_synchronous_dualport_ram.sv
// Self-checking bench for synchronous_dualport_ram.
// The reference model is a plain word array plus an expected read register.
// On each rising edge it applies the access rules from the specification,
// and a compare process checks data_out against it on every falling edge.
// Directed scenarios also check hand-computed literal values.
// RAM_BYPASS_EN selects the write-first expectation for collisions.
module tb_synchronous_dualport_ram;

  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic [A-1:0] read_add = '0;
  logic [A-1:0] write_add = '0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [W-1:0] data_out;

  int errors = 0;
  int checks = 0;
  bit compare_en = 1'b0;

  // Reference model state.
  logic [W-1:0] model_mem [D];
  logic [W-1:0] exp_dout;

  synchronous_dualport_ram #(
    .ram_width(W),
    .ram_depth(D),
    .add_size (A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .read_add (read_add),
    .write_add(write_add),
    .read     (read),
    .write    (write),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < D; i++) model_mem[i] = '0;
    exp_dout = '0;
  endtask

  // Model: applies the access rules at each edge. While reset is low,
  // everything is zero and any in-flight write is lost.
  always @(posedge clk) begin
    if (!rst) begin
      clear_model();
    end else begin
      if (read) begin
        if (int'(read_add) >= D) exp_dout = '0;
`ifdef RAM_BYPASS_EN
        else if (write && read_add == write_add) exp_dout = data_in;
`endif
        else exp_dout = model_mem[read_add];
      end
      if (write && int'(write_add) < D) model_mem[write_add] = data_in;
    end
  end

  // Asserting reset clears the model immediately, without waiting for a clock.
  always @(negedge rst) clear_model();

  // Compare process: on every falling edge, data_out must match the model.
  always @(negedge clk) begin
    if (compare_en) check("model", data_out, exp_dout);
  end

  // Drive one cycle of inputs, wait for the sampling edge, and return at +2.
  task automatic cycle(input logic rd, input logic [A-1:0] ra,
                       input logic wr, input logic [A-1:0] wa,
                       input logic [W-1:0] d);
    read = rd; read_add = ra; write = wr; write_add = wa; data_in = d;
    @(posedge clk);
    #2;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    clear_model();
    #1 rst = 1'b0;
    compare_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    check("reset_dout", data_out, 8'h00);

    // After reset, every word reads as zero.
    for (int i = 0; i < D; i++) begin
      cycle(1'b1, A'(i), 1'b0, '0, '0);
      check("reset_read", data_out, 8'h00);
    end

    // Write then read.
    cycle(1'b0, '0, 1'b1, 4'd3, 8'hA5);
    cycle(1'b0, '0, 1'b1, 4'd12, 8'h3C);
    cycle(1'b1, 4'd3, 1'b0, '0, '0);
    check("read_a5", data_out, 8'hA5);
    cycle(1'b1, 4'd12, 1'b0, '0, '0);
    check("read_3c", data_out, 8'h3C);

    // Read hold: with read low, data_out keeps its value.
    cycle(1'b1, 4'd3, 1'b0, '0, '0);
    check("hold_load", data_out, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'd12, 1'b0, '0, '0);
      check("hold", data_out, 8'hA5);
    end

    // Same-address collision.
    cycle(1'b0, '0, 1'b1, 4'd7, 8'h11);
    cycle(1'b1, 4'd7, 1'b1, 4'd7, 8'h22);
`ifdef RAM_BYPASS_EN
    check("collision", data_out, 8'h22);
`else
    check("collision", data_out, 8'h11);
`endif
    cycle(1'b1, 4'd7, 1'b0, '0, '0);
    check("after_collision", data_out, 8'h22);

    // Random writes, then random reads; the last write to an address wins.
    for (int i = 0; i < 10; i++)
      cycle(1'b0, '0, 1'b1, A'($urandom_range(0, D - 1)), W'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) begin
      logic [A-1:0] ra;
      ra = A'($urandom_range(0, D - 1));
      cycle(1'b1, ra, 1'b0, '0, '0);
      check("rand_read", data_out, model_mem[ra]);
    end

    // Mixed random traffic, with both enables independent.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), A'($urandom), 1'($urandom), A'($urandom), W'($urandom));

    // Reset asserted between edges, in the middle of traffic.
    cycle(1'b0, '0, 1'b1, 4'd0, 8'hFF);
    cycle(1'b1, 4'd0, 1'b0, '0, '0);
    check("pre_reset", data_out, 8'hFF);
    #1 rst = 1'b0;
    #1 check("async_reset", data_out, 8'h00);
    @(posedge clk);
    #2 rst = 1'b1;
    cycle(1'b1, 4'd0, 1'b0, '0, '0);
    check("post_reset_read", data_out, 8'h00);

    @(posedge clk);
    @(negedge clk);
    compare_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
